// File: rtl/kart_state_tracker_if.sv
// kart_state_tracker_if
//   Bundles the update, emission and status signals of kart_state_tracker.
//   Clock and reset are not part of the bundle.
//
//   Handshake rule for the emitted word: a word transfers on a rising edge
//   where out_valid_out=1 and out_ready_in=1. Once out_valid_out is high,
//   out_id_out and out_data_out hold steady until that edge. out_valid_out
//   never depends combinationally on out_ready_in.
//
// Modports
//   master : game-logic / downstream side (drives updates and ready)
//   slave  : the tracker (drives emitted word, flags and debug state)
interface kart_state_tracker_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int STATE_W     = 34,
  parameter int ID_W        = $clog2(NUM_PLAYERS)
);
  logic [NUM_PLAYERS-1:0]         upd_valid_in;
  logic [NUM_PLAYERS*STATE_W-1:0] upd_data_in;
  logic                           out_ready_in;
  logic                           out_valid_out;
  logic [ID_W-1:0]                out_id_out;
  logic [STATE_W-1:0]             out_data_out;
  logic [NUM_PLAYERS-1:0]         dirty_out;
  logic [NUM_PLAYERS-1:0]         stale_out;
  logic                           dbg_state_out;  // 0 = IDLE, 1 = HOLD

  modport master (
    output upd_valid_in, upd_data_in, out_ready_in,
    input  out_valid_out, out_id_out, out_data_out, dirty_out, stale_out,
           dbg_state_out
  );

  modport slave (
    input  upd_valid_in, upd_data_in, out_ready_in,
    output out_valid_out, out_id_out, out_data_out, dirty_out, stale_out,
           dbg_state_out
  );
endinterface

// File: rtl/kart_state_tracker.sv
// kart_state_tracker
//   Per-player state store with change detection and round-robin emission
//   toward the transmit-side clock-crossing buffer (clk_65mhz domain).
//   Each channel keeps its last packed state word; a changed update marks
//   the channel dirty and the emission FSM (IDLE/HOLD) sends dirty channels
//   one word at a time, starting the search just after the last channel
//   sent. A keep-alive counter forces a re-send of the pointer channel after
//   KEEPALIVE_CYCLES idle cycles (0 disables it).
//
// Optional build macro: STALE_TIMEOUT_EN
//   Adds a per-channel age counter (STALE_CYCLES); channels with no update
//   for STALE_CYCLES cycles report stale_out and are skipped by the arbiter
//   while keeping their dirty flag. Without the macro stale_out is 0.
//
// Ports
//   clk_in    : system clock
//   rst_in_n  : asynchronous active-low reset
//   bus       : kart_state_tracker_if.slave (updates, emitted word,
//               dirty/stale flags, FSM debug state)
module kart_state_tracker #(
  parameter int NUM_PLAYERS      = 4,
  parameter int STATE_W          = 34,
  parameter int KEEPALIVE_CYCLES = 1083333,
  parameter int ID_W             = $clog2(NUM_PLAYERS)
`ifdef STALE_TIMEOUT_EN
  , parameter int STALE_CYCLES   = 6500000
`endif
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  kart_state_tracker_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  localparam int KA_W = (KEEPALIVE_CYCLES > 0) ? $clog2(KEEPALIVE_CYCLES + 1) : 1;

  fsm_e                               fsm_q, fsm_d;
  logic [NUM_PLAYERS-1:0][STATE_W-1:0] state_q, state_d;
  logic [NUM_PLAYERS-1:0]             dirty_q, dirty_d;
  logic [ID_W-1:0]                    ptr_q, ptr_d;
  logic [KA_W-1:0]                    ka_cnt_q, ka_cnt_d;
  logic                               out_valid_q, out_valid_d;
  logic [ID_W-1:0]                    out_id_q, out_id_d;
  logic [STATE_W-1:0]                 out_data_q, out_data_d;

  logic [NUM_PLAYERS-1:0] stale;
  logic [NUM_PLAYERS-1:0] eligible;
  logic [ID_W-1:0]        sel_id;
  logic                   sel_found;
  logic                   handshake;
  logic                   ka_fire;

  assign handshake = (fsm_q == HOLD) && bus.out_ready_in;
  assign ka_fire   = (KEEPALIVE_CYCLES != 0) &&
                     (ka_cnt_q == KA_W'(KEEPALIVE_CYCLES - 1));

  // Store and dirty tracking. On a handshake the sent channel is cleared
  // only if the store still matches the word that was sent: an update that
  // changed the channel during HOLD (or on the handshake edge itself) keeps
  // the channel dirty so the newer value goes out in a later round.
  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    if (handshake && (state_q[out_id_q] == out_data_q)) begin
      dirty_d[out_id_q] = 1'b0;
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.upd_valid_in[i]) begin
        state_d[i] = bus.upd_data_in[i*STATE_W +: STATE_W];
        if (state_d[i] != state_q[i]) begin
          dirty_d[i] = 1'b1;
        end
      end
    end
  end

`ifdef STALE_TIMEOUT_EN
  localparam int AGE_W = $clog2(STALE_CYCLES + 1);

  logic [NUM_PLAYERS-1:0][AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.upd_valid_in[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_W'(STALE_CYCLES)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  always_comb begin
    stale = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      stale[i] = (age_q[i] == AGE_W'(STALE_CYCLES));
    end
  end
`else
  assign stale = '0;
`endif

  // Round-robin pick: first eligible channel at or after the pointer.
  always_comb begin
    logic [ID_W-1:0] cand;
    int              idx;
    eligible  = dirty_q & ~stale;
    sel_found = 1'b0;
    sel_id    = ptr_q;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      idx  = (int'(ptr_q) + k) % NUM_PLAYERS;
      cand = ID_W'(idx);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Emission FSM. The captured word comes from state_d so an update landing
  // on the capture edge is what gets sent.
  always_comb begin
    fsm_d       = fsm_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
    ka_cnt_d    = ka_cnt_q;
    case (fsm_q)
      IDLE: begin
        if (sel_found) begin
          fsm_d       = HOLD;
          out_valid_d = 1'b1;
          out_id_d    = sel_id;
          out_data_d  = state_d[sel_id];
        end else if (ka_fire) begin
          fsm_d       = HOLD;
          out_valid_d = 1'b1;
          out_id_d    = ptr_q;
          out_data_d  = state_d[ptr_q];
          ka_cnt_d    = '0;
        end else if (KEEPALIVE_CYCLES != 0) begin
          ka_cnt_d = ka_cnt_q + KA_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready_in) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
          ka_cnt_d    = '0;
          ptr_d       = (out_id_q == ID_W'(NUM_PLAYERS - 1)) ? '0 : out_id_q + ID_W'(1);
        end
      end
      default: begin
        fsm_d       = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      dirty_q     <= '0;
      ptr_q       <= '0;
      ka_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      ka_cnt_q    <= ka_cnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid_out = out_valid_q;
  assign bus.out_id_out    = out_id_q;
  assign bus.out_data_out  = out_data_q;
  assign bus.dirty_out     = dirty_q;
  assign bus.stale_out     = stale;
  assign bus.dbg_state_out = (fsm_q == HOLD);

endmodule
